// File: rtl/rotary_encoder_pkg.sv
// Shared constants and quadrature helpers for the rotary encoder front-end.
package rotary_encoder_pkg;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_POSITION = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EVENT    = 2'd3;

  localparam int unsigned EV_CW    = 0;
  localparam int unsigned EV_CCW   = 1;
  localparam int unsigned EV_PRESS = 2;
  localparam int unsigned EV_ERR   = 3;

  // Debounced {a, b} pin pair.
  typedef enum logic [1:0] {
    QuadS00 = 2'b00,
    QuadS01 = 2'b01,
    QuadS10 = 2'b10,
    QuadS11 = 2'b11
  } quad_state_e;

  typedef enum logic [1:0] {
    MoveNone,
    MoveCw,
    MoveCcw,
    MoveErr
  } quad_move_e;

  // CW order is 11 -> 01 -> 00 -> 10 -> 11; any single-bit change that is not CW is CCW.
  function automatic quad_move_e quad_decode(quad_state_e prev, quad_state_e cur);
    quad_move_e mv;
    logic       cw;
    case (prev)
      QuadS11: cw = (cur == QuadS01);
      QuadS01: cw = (cur == QuadS00);
      QuadS00: cw = (cur == QuadS10);
      default: cw = (cur == QuadS11);
    endcase
    if (prev == cur) begin
      mv = MoveNone;
    end else if ((prev ^ cur) == 2'b11) begin
      mv = MoveErr;
    end else if (cw) begin
      mv = MoveCw;
    end else begin
      mv = MoveCcw;
    end
    return mv;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; idles and resets high.
module enc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/rotary_encoder_decoder.sv
// Rotary encoder / push-button decoder with position counter, W1C events and Avalon-MM regs.
module rotary_encoder_decoder
  import rotary_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned STEPS_PER_DETENT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_btn,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic signed [3:0] StepsPos = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] StepsNeg = -StepsPos;

  logic a_db, b_db, btn_db;

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .raw_i(enc_a), .level_o(a_db)
  );
  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .raw_i(enc_b), .level_o(b_db)
  );
  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
    .clk(clk), .reset_n(reset_n), .raw_i(enc_btn), .level_o(btn_db)
  );

  quad_state_e       prev_ab_q, cur_ab;
  quad_move_e        move;
  logic signed [3:0] sub_q, sub_d, sub_sum;
  logic [CNT_W-1:0]  pos_q, pos_d;
  logic [3:0]        event_q, event_d, ev_set, mask_q, mask_d, w1c;
  logic [31:0]       readdata_q, readdata_d;
  logic              btn_prev_q;
  logic              wr_en, wr_pos, wr_mask, wr_event;
  logic              unused_wdata;

  assign cur_ab   = quad_state_e'({a_db, b_db});
  assign move     = quad_decode(prev_ab_q, cur_ab);
  assign wr_en    = chipselect & ~write_n;
  assign wr_pos   = wr_en && (address == ADDR_POSITION);
  assign wr_mask  = wr_en && (address == ADDR_IRQ_MASK);
  assign wr_event = wr_en && (address == ADDR_EVENT);
  assign unused_wdata = ^writedata;

  always_comb begin
    ev_set  = '0;
    sub_sum = sub_q;
    pos_d   = pos_q;
    case (move)
      MoveCw:  sub_sum = sub_q + 4'sd1;
      MoveCcw: sub_sum = sub_q - 4'sd1;
      MoveErr: ev_set[EV_ERR] = 1'b1;
      default: ;
    endcase
    sub_d = sub_sum;
    if (sub_sum == StepsPos) begin
      pos_d         = pos_q + 1'b1;
      sub_d         = '0;
      ev_set[EV_CW] = 1'b1;
    end else if (sub_sum == StepsNeg) begin
      pos_d          = pos_q - 1'b1;
      sub_d          = '0;
      ev_set[EV_CCW] = 1'b1;
    end else if (cur_ab == QuadS11) begin
      // Back at the detent rest position: drop any partial turn.
      sub_d = '0;
    end
    ev_set[EV_PRESS] = btn_prev_q & ~btn_db;

    // A firmware load overrides a coincident step; the step event still fires.
    if (wr_pos) begin
      pos_d = writedata[CNT_W-1:0];
      sub_d = '0;
    end

    mask_d  = wr_mask ? writedata[3:0] : mask_q;
    w1c     = wr_event ? writedata[3:0] : 4'h0;
    event_d = (event_q & ~w1c) | ev_set;

    readdata_d = '0;
    case (address)
      ADDR_STATUS:   readdata_d = {29'b0, ~btn_db, b_db, a_db};
      ADDR_POSITION: readdata_d = 32'($signed(pos_q));
      ADDR_IRQ_MASK: readdata_d = {28'b0, mask_q};
      default:       readdata_d = {28'b0, event_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab_q  <= QuadS11;
      sub_q      <= '0;
      pos_q      <= '0;
      event_q    <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      btn_prev_q <= 1'b1;
    end else begin
      prev_ab_q  <= cur_ab;
      sub_q      <= sub_d;
      pos_q      <= pos_d;
      event_q    <= event_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      btn_prev_q <= btn_db;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(event_q & mask_q);

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Directed bench for rotary_encoder_decoder with short debounce and hand-computed expectations.
module tb_rotary_encoder_decoder;
  import rotary_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enc_a = 1'b1, enc_b = 1'b1, enc_btn = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] rv;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  rotary_encoder_decoder #(
    .DEBOUNCE_CYCLES(4), .CNT_W(16), .STEPS_PER_DETENT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // All stimulus changes and samples happen on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    tick(1);
    v = readdata;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_ab(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    tick(10);
  endtask

  task automatic cw_detent();
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
  endtask

  task automatic ccw_detent();
    set_ab(1'b1, 1'b0); set_ab(1'b0, 1'b0); set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1);
  endtask

  initial begin
    tick(2);
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    rd_check("idle_status", ADDR_STATUS, 32'h3);
    rd_check("idle_pos", ADDR_POSITION, 32'h0);
    rd_check("idle_mask", ADDR_IRQ_MASK, 32'h0);
    rd_check("idle_event", ADDR_EVENT, 32'h0);

    // One CW detent with the CW event unmasked.
    wr(ADDR_IRQ_MASK, 32'hFFFF_FFF1);
    rd_check("mask_rb", ADDR_IRQ_MASK, 32'h1);
    cw_detent();
    rd_check("cw_pos", ADDR_POSITION, 32'h1);
    rd_check("cw_event", ADDR_EVENT, 32'h1);
    check_eq("cw_irq", {31'b0, irq}, 32'h1);
    wr(ADDR_EVENT, 32'h1);
    check_eq("w1c_irq", {31'b0, irq}, 32'h0);
    rd_check("w1c_event", ADDR_EVENT, 32'h0);

    // CCW through zero, then wrap at the positive limit.
    ccw_detent();
    rd_check("ccw_pos0", ADDR_POSITION, 32'h0);
    ccw_detent();
    rd_check("ccw_neg1", ADDR_POSITION, 32'hFFFF_FFFF);
    rd_check("ccw_event", ADDR_EVENT, 32'h2);
    check_eq("ccw_irq_masked", {31'b0, irq}, 32'h0);
    wr(ADDR_EVENT, 32'hF);
    wr(ADDR_POSITION, 32'h0000_7FFF);
    rd_check("pos_load", ADDR_POSITION, 32'h7FFF);
    cw_detent();
    rd_check("pos_wrap", ADDR_POSITION, 32'hFFFF_8000);
    wr(ADDR_EVENT, 32'hF);

    // Short glitch on A is filtered.
    address = ADDR_STATUS;
    tick(1);
    enc_a = 1'b0;
    tick(3);
    enc_a = 1'b1;
    tick(12);
    check_eq("glitch_status", readdata, 32'h3);
    rd_check("glitch_pos", ADDR_POSITION, 32'hFFFF_8000);
    rd_check("glitch_event", ADDR_EVENT, 32'h0);

    // 8-cycle pulse: stable level flips on edge 6, STATUS shows it one edge later.
    address = ADDR_STATUS;
    tick(1);
    enc_a = 1'b0;
    tick(6);
    check_eq("lat_before", readdata, 32'h3);
    tick(1);
    check_eq("lat_after", readdata, 32'h2);
    tick(1);
    enc_a = 1'b1;
    tick(12);
    rd_check("pulse_status", ADDR_STATUS, 32'h3);
    rd_check("pulse_pos", ADDR_POSITION, 32'hFFFF_8000);
    rd_check("pulse_event", ADDR_EVENT, 32'h0);

    // Button press and release.
    enc_btn = 1'b0;
    tick(20);
    rd_check("btn_status", ADDR_STATUS, 32'h7);
    rd_check("btn_event", ADDR_EVENT, 32'h4);
    enc_btn = 1'b1;
    tick(20);
    rd_check("rel_status", ADDR_STATUS, 32'h3);
    rd_check("rel_event", ADDR_EVENT, 32'h4);
    wr(ADDR_EVENT, 32'h4);
    rd_check("btn_w1c", ADDR_EVENT, 32'h0);

    // Double transition is an error, no count.
    set_ab(1'b0, 1'b0);
    rd_check("err_event", ADDR_EVENT, 32'h8);
    rd_check("err_pos", ADDR_POSITION, 32'hFFFF_8000);
    set_ab(1'b1, 1'b1);
    wr(ADDR_EVENT, 32'hF);

    // Half detent and back.
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b0, 1'b1); set_ab(1'b1, 1'b1);
    rd_check("half_pos", ADDR_POSITION, 32'hFFFF_8000);
    rd_check("half_event", ADDR_EVENT, 32'h0);

    // Partial turn ended by an error jump to 11 must be discarded.
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b1);
    rd_check("part_err", ADDR_EVENT, 32'h8);
    wr(ADDR_EVENT, 32'hF);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0);
    rd_check("subclr_mid", ADDR_POSITION, 32'hFFFF_8000);
    set_ab(1'b1, 1'b0); set_ab(1'b1, 1'b1);
    rd_check("subclr_pos", ADDR_POSITION, 32'hFFFF_8001);
    rd_check("subclr_event", ADDR_EVENT, 32'h1);

    // W1C of bit0 on the same edge the CW event sets: set wins.
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0);
    enc_b = 1'b1;
    tick(6);
    wr(ADDR_EVENT, 32'h1);
    tick(4);
    rd_check("coll_w1c_event", ADDR_EVENT, 32'h1);
    rd_check("coll_w1c_pos", ADDR_POSITION, 32'hFFFF_8002);

    // POSITION write on the same edge as a step: write wins, event still sets.
    wr(ADDR_EVENT, 32'hF);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0); set_ab(1'b1, 1'b0);
    enc_b = 1'b1;
    tick(6);
    wr(ADDR_POSITION, 32'h0000_0100);
    tick(4);
    rd_check("coll_pos", ADDR_POSITION, 32'h100);
    rd_check("coll_pos_event", ADDR_EVENT, 32'h1);

    // Reset mid-rotation, pins left at 00.
    wr(ADDR_IRQ_MASK, 32'hF);
    check_eq("pre_rst_irq", {31'b0, irq}, 32'h1);
    set_ab(1'b0, 1'b1); set_ab(1'b0, 1'b0);
    reset_n = 1'b0;
    tick(1);
    check_eq("mid_rst_readdata", readdata, 32'h0);
    check_eq("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    rd_check("post_rst_event", ADDR_EVENT, 32'h8);
    rd_check("post_rst_pos", ADDR_POSITION, 32'h0);
    rd_check("post_rst_mask", ADDR_IRQ_MASK, 32'h0);
    rd_check("post_rst_status", ADDR_STATUS, 32'h0);
    check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

    rd(ADDR_STATUS, rv);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
